// File: rtl/lc3_control_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lc3_control_if : LC-3 controller <-> datapath control bundle (r1.0) |
// +--------------------------------------------------------------------+
interface lc3_control_if;
   logic [15:0] IR;
   logic        N, Z, P;
   logic        enaMARM, enaPC, enaMDR, enaALU;
   logic        ldPC, ldIR, ldMAR, ldMDR;
   logic        regWE, flagWE, memWE;
   logic [1:0]  selPC;
   logic        selEAB1;
   logic [1:0]  selEAB2;
   logic        selMAR, selMDR;
   logic [1:0]  ALUctrl;
   logic [2:0]  DR, SR1, SR2;
   logic        instr_done;

   modport master (
      input  IR, N, Z, P,
      output enaMARM, enaPC, enaMDR, enaALU,
      output ldPC, ldIR, ldMAR, ldMDR,
      output regWE, flagWE, memWE,
      output selPC, selEAB1, selEAB2, selMAR, selMDR, ALUctrl,
      output DR, SR1, SR2, instr_done
   );

   modport slave (
      output IR, N, Z, P,
      input  enaMARM, enaPC, enaMDR, enaALU,
      input  ldPC, ldIR, ldMAR, ldMDR,
      input  regWE, flagWE, memWE,
      input  selPC, selEAB1, selEAB2, selMAR, selMDR, ALUctrl,
      input  DR, SR1, SR2, instr_done
   );
endinterface
`default_nettype wire

// File: rtl/lc3_control.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lc3_control : multi-cycle fetch/decode/execute FSM for LC-3 (r1.0)  |
// +--------------------------------------------------------------------+
module lc3_control #(
   parameter int MEM_LAT = 1
) (
   input  wire logic         clk,
   input  wire logic         rst,
   lc3_control_if.master     bus
);
   typedef enum logic [3:0] {
      S_F0, S_F1, S_F2, S_DEC, S_ALU, S_LEA, S_BR, S_JMP,
      S_J0, S_J1, S_EA, S_RD, S_WB, S_SM, S_WR
   } state_t;

   localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

   state_t     state, state_nxt;
   logic [3:0] wait_cnt;
   logic       wait_done;
   logic       taken;
   logic [3:0] opcode;

   assign opcode    = bus.IR[15:12];
   assign wait_done = (wait_cnt == 4'd0);
   assign taken     = (bus.IR[11] & bus.N) | (bus.IR[10] & bus.Z) | (bus.IR[9] & bus.P);

   // The counter is preloaded as a memory state is entered, so the state
   // lasts exactly MEM_LAT cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_F0;
         wait_cnt <= 4'd0;
      end else begin
         state <= state_nxt;
         if ((state_nxt != state) &&
             (state_nxt == S_F1 || state_nxt == S_RD || state_nxt == S_WR))
            wait_cnt <= LAT_M1;
         else if (!wait_done)
            wait_cnt <= wait_cnt - 4'd1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_F0:  state_nxt = S_F1;
         S_F1:  if (wait_done) state_nxt = S_F2;
         S_F2:  state_nxt = S_DEC;
         S_DEC: begin
            case (opcode)
               4'b0001, 4'b0101, 4'b1001:          state_nxt = S_ALU;
               4'b1110:                            state_nxt = S_LEA;
               4'b0000:                            state_nxt = S_BR;
               4'b1100:                            state_nxt = S_JMP;
               4'b0100:                            state_nxt = S_J0;
               4'b0010, 4'b0110, 4'b0011, 4'b0111: state_nxt = S_EA;
               default:                            state_nxt = S_F0;
            endcase
         end
         S_J0:  state_nxt = S_J1;
         S_EA:  state_nxt = opcode[0] ? S_SM : S_RD;
         S_RD:  if (wait_done) state_nxt = S_WB;
         S_SM:  state_nxt = S_WR;
         S_WR:  if (wait_done) state_nxt = S_F0;
         default: state_nxt = S_F0;
      endcase
   end

   // Outputs are zeroed combinationally while rst is high so an aborted
   // store or writeback cannot leak a strobe.
   always_comb begin
      bus.enaMARM    = 1'b0;
      bus.enaPC      = 1'b0;
      bus.enaMDR     = 1'b0;
      bus.enaALU     = 1'b0;
      bus.ldPC       = 1'b0;
      bus.ldIR       = 1'b0;
      bus.ldMAR      = 1'b0;
      bus.ldMDR      = 1'b0;
      bus.regWE      = 1'b0;
      bus.flagWE     = 1'b0;
      bus.memWE      = 1'b0;
      bus.selPC      = 2'd0;
      bus.selEAB1    = 1'b0;
      bus.selEAB2    = 2'd0;
      bus.selMAR     = 1'b0;
      bus.selMDR     = 1'b0;
      bus.ALUctrl    = 2'd0;
      bus.DR         = 3'd0;
      bus.SR1        = 3'd0;
      bus.SR2        = 3'd0;
      bus.instr_done = 1'b0;
      if (!rst) begin
         bus.DR  = bus.IR[11:9];
         bus.SR1 = bus.IR[8:6];
         bus.SR2 = bus.IR[2:0];
         case (state)
            S_F0: begin
               bus.enaPC = 1'b1;
               bus.ldMAR = 1'b1;
               bus.ldPC  = 1'b1;
            end
            S_F1, S_RD: begin
               bus.selMDR = 1'b1;
               bus.ldMDR  = wait_done;
            end
            S_F2: begin
               bus.enaMDR = 1'b1;
               bus.ldIR   = 1'b1;
            end
            S_DEC: bus.instr_done = (state_nxt == S_F0);
            S_ALU: begin
               bus.enaALU     = 1'b1;
               bus.regWE      = 1'b1;
               bus.flagWE     = 1'b1;
               bus.instr_done = 1'b1;
               case (opcode)
                  4'b0101: bus.ALUctrl = 2'd1;
                  4'b1001: bus.ALUctrl = 2'd2;
                  default: bus.ALUctrl = 2'd0;
               endcase
            end
            S_LEA: begin
               bus.selEAB2    = 2'd2;
               bus.enaMARM    = 1'b1;
               bus.regWE      = 1'b1;
               bus.flagWE     = 1'b1;
               bus.instr_done = 1'b1;
            end
            S_BR: begin
               bus.selEAB2    = 2'd2;
               bus.selPC      = 2'd1;
               bus.ldPC       = taken;
               bus.instr_done = 1'b1;
            end
            S_JMP: begin
               bus.selEAB1    = 1'b1;
               bus.selPC      = 2'd1;
               bus.ldPC       = 1'b1;
               bus.instr_done = 1'b1;
            end
            S_J0: begin
               bus.enaPC = 1'b1;
               bus.regWE = 1'b1;
               bus.DR    = 3'd7;
            end
            S_J1: begin
               bus.selPC      = 2'd1;
               bus.ldPC       = 1'b1;
               bus.instr_done = 1'b1;
               if (bus.IR[11]) bus.selEAB2 = 2'd3;
               else            bus.selEAB1 = 1'b1;
            end
            S_EA: begin
               bus.enaMARM = 1'b1;
               bus.ldMAR   = 1'b1;
               if (opcode[2]) begin
                  bus.selEAB1 = 1'b1;
                  bus.selEAB2 = 2'd1;
               end else begin
                  bus.selEAB2 = 2'd2;
               end
            end
            S_WB: begin
               bus.enaMDR     = 1'b1;
               bus.regWE      = 1'b1;
               bus.flagWE     = 1'b1;
               bus.instr_done = 1'b1;
            end
            S_SM: begin
               bus.SR1     = bus.IR[11:9];
               bus.ALUctrl = 2'd3;
               bus.enaALU  = 1'b1;
               bus.ldMDR   = 1'b1;
            end
            S_WR: begin
               bus.memWE      = 1'b1;
               bus.instr_done = wait_done;
            end
            default: ;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_lc3_control.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_lc3_control : random + directed bench for lc3_control (r1.0)     |
// +--------------------------------------------------------------------+
module tb_lc3_control;
   typedef struct packed {
      logic       enaMARM, enaPC, enaMDR, enaALU;
      logic       ldPC, ldIR, ldMAR, ldMDR;
      logic       regWE, flagWE, memWE;
      logic [1:0] selPC;
      logic       selEAB1;
      logic [1:0] selEAB2;
      logic       selMAR, selMDR;
      logic [1:0] ALUctrl;
      logic [2:0] DR, SR1, SR2;
      logic       done;
   } ctl_t;

   localparam logic [3:0][3:0] LATS = {4'd15, 4'd3, 4'd2, 4'd1};

   logic        clk = 1'b0;
   logic [15:0] ir_v  [4];
   logic [2:0]  nzp_v [4];
   logic        rst_v [4];
   logic [29:0] obs_v [4];
   ctl_t        exp_q [$];
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   // One controller per memory latency under test.
   for (genvar i = 0; i < 4; i++) begin : g_dut
      lc3_control_if ifc ();
      assign ifc.IR = ir_v[i];
      assign ifc.N  = nzp_v[i][2];
      assign ifc.Z  = nzp_v[i][1];
      assign ifc.P  = nzp_v[i][0];
      assign obs_v[i] = {ifc.enaMARM, ifc.enaPC, ifc.enaMDR, ifc.enaALU,
                         ifc.ldPC, ifc.ldIR, ifc.ldMAR, ifc.ldMDR,
                         ifc.regWE, ifc.flagWE, ifc.memWE,
                         ifc.selPC, ifc.selEAB1, ifc.selEAB2, ifc.selMAR, ifc.selMDR,
                         ifc.ALUctrl, ifc.DR, ifc.SR1, ifc.SR2, ifc.instr_done};
      lc3_control #(.MEM_LAT(int'(LATS[i]))) u_dut (
         .clk (clk),
         .rst (rst_v[i]),
         .bus (ifc.master)
      );
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   function automatic ctl_t base(input logic [15:0] ir);
      ctl_t c = '0;
      c.DR  = ir[11:9];
      c.SR1 = ir[8:6];
      c.SR2 = ir[2:0];
      return c;
   endfunction

   // Instruction-level model: the expected control word of every cycle.
   task automatic build(input logic [15:0] ir, input logic [2:0] nzp, input int lat);
      ctl_t c;
      logic [3:0] op = ir[15:12];
      exp_q.delete();
      c = base(ir); c.enaPC = 1; c.ldMAR = 1; c.ldPC = 1; exp_q.push_back(c);
      for (int k = 0; k < lat; k++) begin
         c = base(ir); c.selMDR = 1; c.ldMDR = (k == lat - 1); exp_q.push_back(c);
      end
      c = base(ir); c.enaMDR = 1; c.ldIR = 1; exp_q.push_back(c);
      c = base(ir);
      if (!(op inside {4'h1, 4'h5, 4'h9, 4'hE, 4'h0, 4'hC, 4'h4, 4'h2, 4'h6, 4'h3, 4'h7})) begin
         c.done = 1; exp_q.push_back(c);
         return;
      end
      exp_q.push_back(c);
      c = base(ir);
      case (op)
         4'h1, 4'h5, 4'h9: begin
            c.enaALU = 1; c.regWE = 1; c.flagWE = 1; c.done = 1;
            c.ALUctrl = (op == 4'h1) ? 2'd0 : (op == 4'h5) ? 2'd1 : 2'd2;
            exp_q.push_back(c);
         end
         4'hE: begin
            c.selEAB2 = 2; c.enaMARM = 1; c.regWE = 1; c.flagWE = 1; c.done = 1;
            exp_q.push_back(c);
         end
         4'h0: begin
            c.selEAB2 = 2; c.selPC = 1; c.done = 1;
            c.ldPC = (ir[11] && nzp[2]) || (ir[10] && nzp[1]) || (ir[9] && nzp[0]);
            exp_q.push_back(c);
         end
         4'hC: begin
            c.selEAB1 = 1; c.selPC = 1; c.ldPC = 1; c.done = 1;
            exp_q.push_back(c);
         end
         4'h4: begin
            c.enaPC = 1; c.regWE = 1; c.DR = 3'd7; exp_q.push_back(c);
            c = base(ir); c.selPC = 1; c.ldPC = 1; c.done = 1;
            if (ir[11]) c.selEAB2 = 3; else c.selEAB1 = 1;
            exp_q.push_back(c);
         end
         default: begin
            c.enaMARM = 1; c.ldMAR = 1;
            if (op == 4'h6 || op == 4'h7) begin c.selEAB1 = 1; c.selEAB2 = 1; end
            else c.selEAB2 = 2;
            exp_q.push_back(c);
            if (op == 4'h2 || op == 4'h6) begin
               for (int k = 0; k < lat; k++) begin
                  c = base(ir); c.selMDR = 1; c.ldMDR = (k == lat - 1); exp_q.push_back(c);
               end
               c = base(ir); c.enaMDR = 1; c.regWE = 1; c.flagWE = 1; c.done = 1;
               exp_q.push_back(c);
            end else begin
               c = base(ir); c.SR1 = ir[11:9]; c.ALUctrl = 3; c.enaALU = 1; c.ldMDR = 1;
               exp_q.push_back(c);
               for (int k = 0; k < lat; k++) begin
                  c = base(ir); c.memWE = 1; c.done = (k == lat - 1); exp_q.push_back(c);
               end
            end
         end
      endcase
   endtask

   task automatic do_reset(input int k);
      rst_v[k] = 1'b1;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         check($sformatf("rst_l%0d_c%0d", LATS[k], j), 32'(obs_v[k]), 32'd0);
         @(posedge clk); #1;
      end
      rst_v[k] = 1'b0;
   endtask

   // Runs one instruction from F0; abort_at >= 0 raises rst in that cycle.
   task automatic run_instr(input int k, input logic [15:0] ir, input logic [2:0] nzp,
                            input int abort_at);
      ctl_t o;
      ir_v[k]  = ir;
      nzp_v[k] = nzp;
      build(ir, nzp, int'(LATS[k]));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i == abort_at) begin
            rst_v[k] = 1'b1;
            @(posedge clk); #1;
            rst_v[k] = 1'b0;
            return;
         end
         @(negedge clk);
         o = ctl_t'(obs_v[k]);
         check($sformatf("l%0d_ir%h_c%0d", LATS[k], ir, i), 32'(o), 32'(exp_q[i]));
         check("bus_onehot", 32'($countones({o.enaMARM, o.enaPC, o.enaMDR, o.enaALU}) <= 1), 32'd1);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      for (int k = 0; k < 4; k++) begin
         rst_v[k] = 1'b1; ir_v[k] = '0; nzp_v[k] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         int lat = int'(LATS[k]);
         do_reset(k);
         run_instr(k, 16'h1283, 3'b000, -1);
         run_instr(k, 16'h0405, 3'b010, -1);
         run_instr(k, 16'h0405, 3'b101, -1);
         run_instr(k, 16'h0E00, 3'b111, -1);
         run_instr(k, 16'h2A10, 3'b000, -1);
         run_instr(k, 16'h3610, 3'b000, -1);
         run_instr(k, 16'h4805, 3'b000, -1);
         run_instr(k, 16'h4080, 3'b000, -1);
         run_instr(k, 16'h3610, 3'b000, lat + 5);
         run_instr(k, 16'h5283, 3'b000, -1);
         run_instr(k, 16'hF025, 3'b000, -1);
         for (int r = 0; r < 40; r++) begin
            logic [15:0] ir  = 16'($urandom);
            logic [2:0]  nzp = 3'($urandom);
            int          ab  = -1;
            if ($urandom_range(0, 7) == 0) begin
               build(ir, nzp, lat);
               ab = $urandom_range(0, exp_q.size() - 1);
            end
            run_instr(k, ir, nzp, ab);
         end
         rst_v[k] = 1'b1;
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
